conv_unit: RTL and testbench

Multi-cycle numeric conversion unit for the WebAssembly CPU. It executes the conversion opcode group: wrap, extend, reinterpret in both directions for 32 and 64 bits, and float-to-int truncation with trapping. It sits beside the ALU, fed from the stack-operand stage over a valid/ready handshake. It returns a 64-bit result, a type tag and a trap code.

---
 rtl/conv_unit_pkg.sv | 38 +++
 rtl/conv_trunc_shifter.sv | 41 ++++
 rtl/conv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_conv_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_unit_pkg.sv
// Shared constants for the conversion unit: FSM states, type tags, trap codes
// and the Wasm opcode bytes it decodes.
package conv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIX   = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  localparam logic [2:0] TRAP_NONE        = 3'd0;
  localparam logic [2:0] TRAP_INT_OVF     = 3'd4;
  localparam logic [2:0] TRAP_INVALID_CVT = 3'd5;
  localparam logic [2:0] TRAP_UNSUPPORTED = 3'd6;

  localparam logic [7:0] OP_I32_WRAP_I64        = 8'hA7;
  localparam logic [7:0] OP_I32_TRUNC_F32_S     = 8'hA8;
  localparam logic [7:0] OP_I32_TRUNC_F32_U     = 8'hA9;
  localparam logic [7:0] OP_I32_TRUNC_F64_S     = 8'hAA;
  localparam logic [7:0] OP_I32_TRUNC_F64_U     = 8'hAB;
  localparam logic [7:0] OP_I64_EXTEND_I32_S    = 8'hAC;
  localparam logic [7:0] OP_I64_EXTEND_I32_U    = 8'hAD;
  localparam logic [7:0] OP_I64_TRUNC_F32_S     = 8'hAE;
  localparam logic [7:0] OP_I64_TRUNC_F32_U     = 8'hAF;
  localparam logic [7:0] OP_I64_TRUNC_F64_S     = 8'hB0;
  localparam logic [7:0] OP_I64_TRUNC_F64_U     = 8'hB1;
  localparam logic [7:0] OP_I32_REINTERPRET_F32 = 8'hBC;
  localparam logic [7:0] OP_I64_REINTERPRET_F64 = 8'hBD;
  localparam logic [7:0] OP_F32_REINTERPRET_I32 = 8'hBE;
  localparam logic [7:0] OP_F64_REINTERPRET_I64 = 8'hBF;

endpackage

// File: rtl/conv_trunc_shifter.sv
// Iterative right shifter: moves SHIFT_STEP bits per cycle until the
// remaining count is exhausted, clamping the last step.
module conv_trunc_shifter #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] load_value,
  input  logic [6:0]  load_count,
  output logic [63:0] value,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] STEP = 7'(SHIFT_STEP);

  logic [6:0] remaining;
  logic [6:0] step;

  always_comb begin
    step = (remaining < STEP) ? remaining : STEP;
    busy = (remaining != 7'd0);
    // done marks the cycle whose edge performs the final step
    done = busy && (remaining <= STEP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value     <= '0;
      remaining <= '0;
    end else if (start) begin
      value     <= load_value;
      remaining <= load_count;
    end else if (busy) begin
      value     <= value >> step;
      remaining <= remaining - step;
    end
  end

endmodule

// File: rtl/conv_unit.sv
// Wasm conversion unit: decodes wrap/extend/reinterpret/trunc opcodes,
// classifies float operands and runs truncations through an iterative shifter.
module conv_unit
  import conv_unit_pkg::*;
#(
  parameter int SHIFT_STEP   = 8,
  parameter bit ENABLE_TRUNC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [63:0] in_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [1:0]  out_type,
  output logic [2:0]  out_trap
);

  // Handshake: an op transfers on an edge with in_valid & in_ready; a result
  // transfers on an edge with out_valid & out_ready and is held stable until then.

  conv_state_t state, state_next;

  logic        accept;
  logic        dec_supported, dec_trunc, dec_src64, dec_dst64, dec_signed;
  logic [1:0]  dec_type;
  logic [63:0] dec_simple;

  logic               f_sign, f_frac_zero, f_exp_max;
  logic [10:0]        f_exp_raw;
  logic signed [12:0] f_exp, w_max;
  logic [63:0]        f_mant;
  logic [6:0]         shift_cnt;

  logic [2:0]  cls_trap;
  logic        cls_shift;
  logic [63:0] acc_result;

  logic        sign_q, dst64_q;
  logic [63:0] sh_value, fixed;
  logic        sh_busy, sh_done, sh_start;

  assign in_ready  = (state == ST_IDLE) && reset;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    dec_supported = 1'b1;
    dec_trunc     = 1'b0;
    dec_src64     = 1'b0;
    dec_dst64     = 1'b0;
    dec_signed    = ~in_opcode[0];
    dec_type      = TYPE_I32;
    dec_simple    = '0;
    case (in_opcode)
      OP_I32_WRAP_I64:                         dec_simple = {32'b0, in_operand[31:0]};
      OP_I32_TRUNC_F32_S, OP_I32_TRUNC_F32_U:  dec_trunc = 1'b1;
      OP_I32_TRUNC_F64_S, OP_I32_TRUNC_F64_U: begin
        dec_trunc = 1'b1;
        dec_src64 = 1'b1;
      end
      OP_I64_TRUNC_F32_S, OP_I64_TRUNC_F32_U: begin
        dec_trunc = 1'b1;
        dec_dst64 = 1'b1;
        dec_type  = TYPE_I64;
      end
      OP_I64_TRUNC_F64_S, OP_I64_TRUNC_F64_U: begin
        dec_trunc = 1'b1;
        dec_src64 = 1'b1;
        dec_dst64 = 1'b1;
        dec_type  = TYPE_I64;
      end
      OP_I64_EXTEND_I32_S: begin
        dec_type   = TYPE_I64;
        dec_simple = {{32{in_operand[31]}}, in_operand[31:0]};
      end
      OP_I64_EXTEND_I32_U: begin
        dec_type   = TYPE_I64;
        dec_simple = {32'b0, in_operand[31:0]};
      end
      OP_I32_REINTERPRET_F32:                  dec_simple = {32'b0, in_operand[31:0]};
      OP_I64_REINTERPRET_F64: begin
        dec_type   = TYPE_I64;
        dec_simple = in_operand;
      end
      OP_F32_REINTERPRET_I32: begin
        dec_type   = TYPE_F32;
        dec_simple = {32'b0, in_operand[31:0]};
      end
      OP_F64_REINTERPRET_I64: begin
        dec_type   = TYPE_F64;
        dec_simple = in_operand;
      end
      default: dec_supported = 1'b0;
    endcase
  end

  // Float unpack: mantissa left-aligned with the hidden bit at bit 63.
  always_comb begin
    f_sign      = dec_src64 ? in_operand[63] : in_operand[31];
    f_exp_raw   = dec_src64 ? in_operand[62:52] : {3'b000, in_operand[30:23]};
    f_frac_zero = dec_src64 ? (in_operand[51:0] == 52'd0) : (in_operand[22:0] == 23'd0);
    f_exp_max   = dec_src64 ? (in_operand[62:52] == 11'h7FF) : (in_operand[30:23] == 8'hFF);
    f_exp       = $signed({2'b00, f_exp_raw}) - (dec_src64 ? 13'sd1023 : 13'sd127);
    f_mant      = dec_src64 ? {1'b1, in_operand[51:0], 11'b0} : {1'b1, in_operand[22:0], 40'b0};
    w_max       = dec_dst64 ? 13'sd63 : 13'sd31;
    shift_cnt   = 7'd63 - {1'b0, f_exp[5:0]};
  end

  always_comb begin
    cls_trap  = TRAP_NONE;
    cls_shift = 1'b0;
    if (!dec_supported || (dec_trunc && (ENABLE_TRUNC == 1'b0))) begin
      cls_trap = TRAP_UNSUPPORTED;
    end else if (dec_trunc) begin
      if (f_exp_max) begin
        cls_trap = f_frac_zero ? TRAP_INT_OVF : TRAP_INVALID_CVT;
      end else if (f_exp < 13'sd0) begin
        cls_trap = TRAP_NONE;
      end else if (dec_signed) begin
        // only -2^(W-1) exactly survives at the top exponent
        if ((f_exp > w_max) || ((f_exp == w_max) && !(f_sign && f_frac_zero)))
          cls_trap = TRAP_INT_OVF;
        else
          cls_shift = 1'b1;
      end else begin
        if ((f_exp > w_max) || f_sign)
          cls_trap = TRAP_INT_OVF;
        else
          cls_shift = 1'b1;
      end
    end
    acc_result = (dec_supported && !dec_trunc) ? dec_simple : 64'd0;
  end

  assign sh_start = accept && cls_shift;

  generate
    if (ENABLE_TRUNC) begin : g_shifter
      conv_trunc_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .start      (sh_start),
        .load_value (f_mant),
        .load_count (shift_cnt),
        .value      (sh_value),
        .busy       (sh_busy),
        .done       (sh_done)
      );
    end else begin : g_no_shifter
      assign sh_value = '0;
      assign sh_busy  = 1'b0;
      assign sh_done  = 1'b0;
    end
  endgenerate

  assign fixed = sign_q ? (~sh_value + 64'd1) : sh_value;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          // a zero shift count has nothing to shift and goes straight to the sign fix
          if (cls_shift) state_next = (shift_cnt == 7'd0) ? ST_FIX : ST_SHIFT;
          else           state_next = ST_DONE;
        end
      end
      ST_SHIFT: if (!sh_busy || sh_done) state_next = ST_FIX;
      ST_FIX:   state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_result <= '0;
      out_type   <= '0;
      out_trap   <= '0;
      sign_q     <= 1'b0;
      dst64_q    <= 1'b0;
    end else if (accept) begin
      out_result <= acc_result;
      out_type   <= (cls_trap == TRAP_UNSUPPORTED) ? TYPE_I32 : dec_type;
      out_trap   <= cls_trap;
      sign_q     <= f_sign;
      dst64_q    <= dec_dst64;
    end else if (state == ST_FIX) begin
      out_result <= dst64_q ? fixed : {32'b0, fixed[31:0]};
    end
  end

endmodule

// File: tb/tb_conv_unit.sv
// Directed self-checking bench for conv_unit with hand-computed vectors.
module tb_conv_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [63:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [1:0]  out_type;
  logic [2:0]  out_trap;

  int checks = 0;
  int errors = 0;

  conv_unit #(.SHIFT_STEP(8), .ENABLE_TRUNC(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_type   (out_type),
    .out_trap   (out_trap)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drivers: all end at posedge+1
  task automatic issue_op(input logic [7:0] op, input logic [63:0] val, output int lat);
    int wcnt;
    in_opcode  = op;
    in_operand = val;
    in_valid   = 1'b1;
    wcnt = 0;
    while (!in_ready && wcnt < 100) begin
      @(posedge clk); #1;
      wcnt++;
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_opcode  = 8'h00;
    in_operand = 64'hDEAD_DEAD_DEAD_DEAD;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%02h: out_valid never rose", op);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b need 0 0", in_ready, out_valid);
    end
    checks++;
    if (out_result !== 64'd0 || out_type !== 2'd0 || out_trap !== 3'd0) begin
      errors++;
      $display("FAIL reset_out: res=%h type=%0d trap=%0d need 0", out_result, out_type, out_trap);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_simple();
    logic [7:0]  ops   [7] = '{8'hBC, 8'hAC, 8'hAD, 8'hA7, 8'hBD, 8'hBE, 8'hBF};
    logic [63:0] vals  [7] = '{64'hFFFF_FFFF_C000_0000, 64'h0000_0000_8000_0000,
                               64'h0000_0000_8000_0000, 64'h1234_5678_9ABC_DEF0,
                               64'h4009_21FB_5444_2D18, 64'h1111_2222_3F80_0000,
                               64'hC000_0000_0000_0001};
    logic [63:0] exps  [7] = '{64'h0000_0000_C000_0000, 64'hFFFF_FFFF_8000_0000,
                               64'h0000_0000_8000_0000, 64'h0000_0000_9ABC_DEF0,
                               64'h4009_21FB_5444_2D18, 64'h0000_0000_3F80_0000,
                               64'hC000_0000_0000_0001};
    logic [1:0]  types [7] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue_op(ops[i], vals[i], lat);
      checks++;
      if (out_result !== exps[i] || out_type !== types[i] || out_trap !== 3'd0 || lat != 1) begin
        errors++;
        $display("FAIL simple_%02h: res=%h type=%0d trap=%0d lat=%0d need %h %0d 0 1",
                 ops[i], out_result, out_type, out_trap, lat, exps[i], types[i]);
      end
      consume();
    end
  endtask

  task automatic test_trunc();
    // -123.456, -2^31, 2^32-256 unsigned, upper bits ignored, -1.0 to i64,
    // 2^52+1 f64 unsigned, -2^63 exact, -0.5 unsigned
    logic [7:0]  ops  [8] = '{8'hA8, 8'hA8, 8'hA9, 8'hA8, 8'hAE, 8'hB1, 8'hB0, 8'hA9};
    logic [63:0] vals [8] = '{64'h0000_0000_C2F6_E979, 64'h0000_0000_CF00_0000,
                              64'h0000_0000_4F7F_FFFF, 64'hDEAD_BEEF_C2F6_E979,
                              64'h0000_0000_BF80_0000, 64'h4330_0000_0000_0001,
                              64'hC3E0_0000_0000_0000, 64'h0000_0000_BF00_0000};
    logic [63:0] exps [8] = '{64'h0000_0000_FFFF_FF85, 64'h0000_0000_8000_0000,
                              64'h0000_0000_FFFF_FF00, 64'h0000_0000_FFFF_FF85,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h0010_0000_0000_0001,
                              64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000};
    logic [1:0]  types [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    int          lats [8] = '{10, 6, 6, 10, 10, 4, 2, 1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue_op(ops[i], vals[i], lat);
      checks++;
      if (out_result !== exps[i] || out_type !== types[i] || out_trap !== 3'd0 || lat != lats[i]) begin
        errors++;
        $display("FAIL trunc_%0d op=%02h: res=%h type=%0d trap=%0d lat=%0d need %h %0d 0 %0d",
                 i, ops[i], out_result, out_type, out_trap, lat, exps[i], types[i], lats[i]);
      end
      consume();
    end
  endtask

  task automatic test_traps();
    // +2^31 signed, NaN, 2^32 unsigned, -1.0 unsigned, f64 +Inf, f64 NaN to i64, bad opcode
    logic [7:0]  ops   [7] = '{8'hA8, 8'hA8, 8'hA9, 8'hAF, 8'hAA, 8'hB0, 8'h6A};
    logic [63:0] vals  [7] = '{64'h0000_0000_4F00_0000, 64'h0000_0000_7FC0_0000,
                               64'h0000_0000_4F80_0000, 64'h0000_0000_BF80_0000,
                               64'h7FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000,
                               64'h1234_5678_9ABC_DEF0};
    logic [2:0]  traps [7] = '{3'd4, 3'd5, 3'd4, 3'd4, 3'd4, 3'd5, 3'd6};
    logic [1:0]  types [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue_op(ops[i], vals[i], lat);
      checks++;
      if (out_result !== 64'd0 || out_trap !== traps[i] || out_type !== types[i] || lat != 1) begin
        errors++;
        $display("FAIL trap_%0d op=%02h: res=%h type=%0d trap=%0d lat=%0d need 0 %0d %0d 1",
                 i, ops[i], out_result, out_type, out_trap, lat, types[i], traps[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue_op(8'hAC, 64'h0000_0000_8765_4321, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 64'hFFFF_FFFF_8765_4321 ||
          out_type !== 2'd1 || out_trap !== 3'd0) begin
        errors++;
        $display("FAIL hold_%0d: v=%b rdy=%b res=%h type=%0d trap=%0d need 1 0 ffffffff87654321 1 0",
                 i, out_valid, in_ready, out_result, out_type, out_trap);
      end
      @(posedge clk); #1;
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    in_opcode  = 8'hA8;
    in_operand = 64'h0000_0000_C2F6_E979;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b need 0 0", out_valid, in_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: in_ready=%b out_valid=%b need 1 0", in_ready, out_valid);
    end
    issue_op(8'hA8, 64'h0000_0000_CF00_0000, lat);
    checks++;
    if (out_result !== 64'h0000_0000_8000_0000 || out_trap !== 3'd0 || lat != 6) begin
      errors++;
      $display("FAIL post_reset_op: res=%h trap=%0d lat=%0d need 80000000 0 6",
               out_result, out_trap, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] v;
    for (int i = 0; i < 4; i++) begin
      v = {32'h0, $urandom_range(32'hFFFF_FFFF, 0)};
      issue_op(8'hAD, v, lat);
      checks++;
      if (out_result !== {32'h0, v[31:0]} || out_type !== 2'd1 || lat != 1) begin
        errors++;
        $display("FAIL b2b_%0d: res=%h type=%0d lat=%0d need %h 1 1",
                 i, out_result, out_type, lat, {32'h0, v[31:0]});
      end
      consume();
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: in_ready=%b need 1", i, in_ready);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_opcode  = 8'h00;
    in_operand = 64'd0;
    out_ready  = 1'b0;
    test_reset();
    test_simple();
    test_trunc();
    test_traps();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
